// File: rtl/gpu_pkg.sv
// -----------------------------------------------------------------------------
// gpu_pkg
// Shared definitions for the GPU pixel pipeline.
//   - screen / layer / address sizing constants (GPU_*)
//   - cfg_field_e    : descriptor field selector used by the CPU write port
//   - CTRL_*_BIT     : bit positions inside the CTRL field
//   - layer_desc_t   : one layer's rectangle, texture base and control bits
//   - desc_write()   : applies one field write to a descriptor
// Optional feature macro: LAYER_HIT_TEST_HFLIP_EN (stores CTRL bit1 as hflip).
// -----------------------------------------------------------------------------
package gpu_pkg;

   localparam int GPU_HOR_PIX     = 480;
   localparam int GPU_VER_PIX     = 272;
   localparam int GPU_NUM_LAYERS  = 32;
   localparam int GPU_X_DEPTH     = $clog2(GPU_HOR_PIX);
   localparam int GPU_Y_DEPTH     = $clog2(GPU_VER_PIX);
   localparam int GPU_LAYER_DEPTH = $clog2(GPU_NUM_LAYERS);
   localparam int GPU_ADDR_W      = 24;

   typedef enum logic [2:0] {
      FLD_X0   = 3'd0,
      FLD_Y0   = 3'd1,
      FLD_W    = 3'd2,
      FLD_H    = 3'd3,
      FLD_BASE = 3'd4,
      FLD_CTRL = 3'd5
   } cfg_field_e;

   localparam int CTRL_EN_BIT    = 0;
   localparam int CTRL_HFLIP_BIT = 1;

   typedef struct packed {
      logic [GPU_X_DEPTH-1:0] x0;
      logic [GPU_Y_DEPTH-1:0] y0;
      logic [GPU_X_DEPTH-1:0] w;
      logic [GPU_Y_DEPTH-1:0] h;
      logic [GPU_ADDR_W-1:0]  base;
      logic                   en;
      logic                   hflip;
   } layer_desc_t;

   // Data is LSB-aligned; each field keeps only its own width.
   // Unknown field codes leave the descriptor untouched.
   function automatic layer_desc_t desc_write(input layer_desc_t     d,
                                              input logic [2:0]      field,
                                              input logic [GPU_ADDR_W-1:0] data);
      layer_desc_t r;
      r = d;
      case (field)
         FLD_X0:   r.x0   = data[GPU_X_DEPTH-1:0];
         FLD_Y0:   r.y0   = data[GPU_Y_DEPTH-1:0];
         FLD_W:    r.w    = data[GPU_X_DEPTH-1:0];
         FLD_H:    r.h    = data[GPU_Y_DEPTH-1:0];
         FLD_BASE: r.base = data;
         FLD_CTRL: begin
            r.en = data[CTRL_EN_BIT];
`ifdef LAYER_HIT_TEST_HFLIP_EN
            r.hflip = data[CTRL_HFLIP_BIT];
`else
            r.hflip = 1'b0;
`endif
         end
         default: r = d;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/layer_desc_bank.sv
// -----------------------------------------------------------------------------
// layer_desc_bank
// Double-buffered per-layer descriptors. The CPU writes the shadow set; a
// requested commit copies shadow -> active at the next frame start, and the
// read port bypasses to shadow in that cycle so the frame-start tuple already
// sees the new values.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cfg_we/layer/field/data   shadow write port
//   cfg_commit      request a copy at the next frame start
//   frame_start     current input tuple is (0,0,0) and valid
//   rd_layer        layer to read
//   rd_desc         descriptor seen by the current tuple (bypassed)
//   commit_pending  commit requested, not yet applied
// Optional feature macro: LAYER_HIT_TEST_HFLIP_EN (via gpu_pkg::desc_write).
// -----------------------------------------------------------------------------
module layer_desc_bank
   import gpu_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cfg_we,
   input  logic [GPU_LAYER_DEPTH-1:0] cfg_layer,
   input  logic [2:0]                 cfg_field,
   input  logic [GPU_ADDR_W-1:0]      cfg_data,
   input  logic                       cfg_commit,
   input  logic                       frame_start,
   input  logic [GPU_LAYER_DEPTH-1:0] rd_layer,
   output layer_desc_t                rd_desc,
   output logic                       commit_pending
);

   layer_desc_t shadow [GPU_NUM_LAYERS];
   layer_desc_t active [GPU_NUM_LAYERS];
   logic        commit_now;

   assign commit_now = frame_start & commit_pending;

   // Shadow is read before this cycle's write lands, so the bypass and the
   // bulk copy both see the pre-write shadow value.
   assign rd_desc = commit_now ? shadow[rd_layer] : active[rd_layer];

   // NOTE: state is updated with <= so every register samples the values of
   // the previous cycle; blocking = here would make the copy order-dependent.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the descriptor arrays are reset on purpose -- reset must leave
         // every layer disabled, so these are registers, not a RAM macro.
         for (int i = 0; i < GPU_NUM_LAYERS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
         commit_pending <= 1'b0;
      end else begin
         if (commit_now) begin
            for (int i = 0; i < GPU_NUM_LAYERS; i++) begin
               active[i] <= shadow[i];
            end
         end
         if (cfg_we && (cfg_field <= FLD_CTRL)) begin
            shadow[cfg_layer] <= desc_write(shadow[cfg_layer], cfg_field, cfg_data);
         end
         // A commit arriving on a frame start waits for the following one.
         commit_pending <= cfg_commit | (commit_pending & ~frame_start);
      end
   end

endmodule

// File: rtl/layer_hit_test.sv
// -----------------------------------------------------------------------------
// layer_hit_test
// GPU pipeline stage 2: for each (layer, x, y) tuple, decides whether the
// pixel lies inside that layer's enabled rectangle and computes the texel
// address BASE + dy*W + dx. Fixed 2-cycle latency, no backpressure.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/layer/x/y        tuple from the pixel/layer counter
//   cfg_we/layer/field/data   shadow descriptor write port
//   cfg_commit                request shadow->active copy at next frame start
//   commit_pending            commit requested, not yet applied
//   out_valid/layer/x/y       delayed tuple
//   out_hit                   pixel inside an enabled layer rectangle
//   out_addr                  texel address, 0 on a miss
// Optional feature macro: LAYER_HIT_TEST_HFLIP_EN (CTRL bit1 mirrors dx).
// The descriptor bank is sized by the gpu_pkg constants, which must match
// the parameters below.
// -----------------------------------------------------------------------------
module layer_hit_test
   import gpu_pkg::*;
#(
   parameter int HOR_PIX     = GPU_HOR_PIX,
   parameter int VER_PIX     = GPU_VER_PIX,
   parameter int NUM_LAYERS  = GPU_NUM_LAYERS,
   parameter int X_DEPTH     = $clog2(HOR_PIX),
   parameter int Y_DEPTH     = $clog2(VER_PIX),
   parameter int LAYER_DEPTH = $clog2(NUM_LAYERS),
   parameter int ADDR_W      = GPU_ADDR_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [LAYER_DEPTH-1:0] in_layer,
   input  logic [X_DEPTH-1:0]     in_x,
   input  logic [Y_DEPTH-1:0]     in_y,
   input  logic                   cfg_we,
   input  logic [LAYER_DEPTH-1:0] cfg_layer,
   input  logic [2:0]             cfg_field,
   input  logic [ADDR_W-1:0]      cfg_data,
   input  logic                   cfg_commit,
   output logic                   commit_pending,
   output logic                   out_valid,
   output logic [LAYER_DEPTH-1:0] out_layer,
   output logic [X_DEPTH-1:0]     out_x,
   output logic [Y_DEPTH-1:0]     out_y,
   output logic                   out_hit,
   output logic [ADDR_W-1:0]      out_addr
);

   logic        frame_start;
   layer_desc_t desc;

   assign frame_start = in_valid && (in_layer == '0) && (in_x == '0) && (in_y == '0);

   layer_desc_bank u_bank (
      .clk            (clk),
      .rst            (rst),
      .cfg_we         (cfg_we),
      .cfg_layer      (cfg_layer),
      .cfg_field      (cfg_field),
      .cfg_data       (cfg_data),
      .cfg_commit     (cfg_commit),
      .frame_start    (frame_start),
      .rd_layer       (in_layer),
      .rd_desc        (desc),
      .commit_pending (commit_pending)
   );

   // ---------------- stage 1: rectangle test and offsets ----------------
   logic [X_DEPTH:0]   x_lo, x_hi;
   logic [Y_DEPTH:0]   y_lo, y_hi;
   logic [X_DEPTH-1:0] dx_raw, dx_c;
   logic [Y_DEPTH-1:0] dy_c;
   logic               hit_c;

   // NOTE: every output of this block gets a default first so no path leaves
   // a variable unassigned, which would infer a latch.
   always_comb begin
      x_lo   = '0;
      x_hi   = '0;
      y_lo   = '0;
      y_hi   = '0;
      dx_raw = '0;
      dx_c   = '0;
      dy_c   = '0;
      hit_c  = 1'b0;

      // One extra bit so X0+W / Y0+H past the screen edge cannot wrap.
      x_lo  = {1'b0, desc.x0};
      x_hi  = x_lo + {1'b0, desc.w};
      y_lo  = {1'b0, desc.y0};
      y_hi  = y_lo + {1'b0, desc.h};
      hit_c = desc.en
              && ({1'b0, in_x} >= x_lo) && ({1'b0, in_x} < x_hi)
              && ({1'b0, in_y} >= y_lo) && ({1'b0, in_y} < y_hi);

      dx_raw = in_x - desc.x0;
      dy_c   = in_y - desc.y0;
      // hflip is only ever stored when the mirror feature is built in.
      dx_c   = desc.hflip ? (desc.w - dx_raw - X_DEPTH'(1)) : dx_raw;
   end

   logic                   s1_valid;
   logic [LAYER_DEPTH-1:0] s1_layer;
   logic [X_DEPTH-1:0]     s1_x;
   logic [Y_DEPTH-1:0]     s1_y;
   logic                   s1_hit;
   logic [X_DEPTH-1:0]     s1_dx;
   logic [Y_DEPTH-1:0]     s1_dy;
   logic [X_DEPTH-1:0]     s1_w;
   logic [ADDR_W-1:0]      s1_base;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_layer <= '0;
         s1_x     <= '0;
         s1_y     <= '0;
         s1_hit   <= 1'b0;
         s1_dx    <= '0;
         s1_dy    <= '0;
         s1_w     <= '0;
         s1_base  <= '0;
      end else begin
         s1_valid <= in_valid;
         s1_layer <= in_layer;
         s1_x     <= in_x;
         s1_y     <= in_y;
         s1_hit   <= in_valid & hit_c;
         s1_dx    <= dx_c;
         s1_dy    <= dy_c;
         s1_w     <= desc.w;
         s1_base  <= desc.base;
      end
   end

   // ---------------- stage 2: texel address ----------------
   logic [ADDR_W-1:0] addr_c;

   // Wraps modulo 2^ADDR_W by construction of the result width.
   assign addr_c = s1_base + ADDR_W'(s1_dy) * ADDR_W'(s1_w) + ADDR_W'(s1_dx);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_layer <= '0;
         out_x     <= '0;
         out_y     <= '0;
         out_hit   <= 1'b0;
         out_addr  <= '0;
      end else begin
         out_valid <= s1_valid;
         out_layer <= s1_layer;
         out_x     <= s1_x;
         out_y     <= s1_y;
         out_hit   <= s1_hit;
         out_addr  <= s1_hit ? addr_c : '0;
      end
   end

endmodule

// File: tb/tb_layer_hit_test.sv
// -----------------------------------------------------------------------------
// tb_layer_hit_test
// Self-checking bench for layer_hit_test. A behavioural model (integer
// descriptors, a pending flag and a one-entry result delay) predicts every
// output after each clock edge; directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_layer_hit_test;

   localparam int NL = 32;
   localparam int AW = 24;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [4:0]  in_layer;
   logic [8:0]  in_x;
   logic [8:0]  in_y;
   logic        cfg_we;
   logic [4:0]  cfg_layer;
   logic [2:0]  cfg_field;
   logic [23:0] cfg_data;
   logic        cfg_commit;
   logic        commit_pending;
   logic        out_valid;
   logic [4:0]  out_layer;
   logic [8:0]  out_x;
   logic [8:0]  out_y;
   logic        out_hit;
   logic [23:0] out_addr;

   layer_hit_test dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_layer       (in_layer),
      .in_x           (in_x),
      .in_y           (in_y),
      .cfg_we         (cfg_we),
      .cfg_layer      (cfg_layer),
      .cfg_field      (cfg_field),
      .cfg_data       (cfg_data),
      .cfg_commit     (cfg_commit),
      .commit_pending (commit_pending),
      .out_valid      (out_valid),
      .out_layer      (out_layer),
      .out_x          (out_x),
      .out_y          (out_y),
      .out_hit        (out_hit),
      .out_addr       (out_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct { int x0, y0, w, h, base, en, hf; } mdesc_t;
   typedef struct { bit v; int layer, x, y; bit hit; int addr; } res_t;

   mdesc_t sh [NL];
   mdesc_t ac [NL];
   bit     m_pend;
   res_t   p1, expo;

   function automatic res_t evaluate(mdesc_t d, bit v, int l, int x, int y);
      res_t r;
      int   dx;
      r.v = v; r.layer = l; r.x = x; r.y = y; r.hit = 0; r.addr = 0;
      if (v && d.en != 0 && x >= d.x0 && x < d.x0 + d.w && y >= d.y0 && y < d.y0 + d.h) begin
         r.hit = 1;
         dx = (d.hf != 0) ? (d.w - 1 - (x - d.x0)) : (x - d.x0);
         r.addr = (d.base + (y - d.y0) * d.w + dx) % (1 << AW);
      end
      return r;
   endfunction

   task automatic model_edge();
      res_t   r;
      mdesc_t d;
      bit     fs;
      int     l, f, v;
      if (rst) begin
         for (int i = 0; i < NL; i++) begin
            sh[i] = '{default: 0};
            ac[i] = '{default: 0};
         end
         m_pend = 0;
         p1   = '{default: 0};
         expo = '{default: 0};
      end else begin
         fs = in_valid && in_layer == 0 && in_x == 0 && in_y == 0;
         d  = (fs && m_pend) ? sh[in_layer] : ac[in_layer];
         r  = evaluate(d, in_valid, int'(in_layer), int'(in_x), int'(in_y));
         if (fs && m_pend) ac = sh;
         if (cfg_we) begin
            l = int'(cfg_layer); f = int'(cfg_field); v = int'(cfg_data);
            case (f)
               0: sh[l].x0   = v % 512;
               1: sh[l].y0   = v % 512;
               2: sh[l].w    = v % 512;
               3: sh[l].h    = v % 512;
               4: sh[l].base = v;
               5: begin
                  sh[l].en = v % 2;
`ifdef LAYER_HIT_TEST_HFLIP_EN
                  sh[l].hf = (v / 2) % 2;
`else
                  sh[l].hf = 0;
`endif
               end
               default: ;
            endcase
         end
         m_pend = cfg_commit || (m_pend && !fs);
         expo = p1;
         p1   = r;
      end
   endtask

   task automatic compare();
      check("out_valid", out_valid, expo.v);
      check("out_hit", out_hit, expo.hit);
      check("out_addr", out_addr, expo.addr);
      check("commit_pending", commit_pending, m_pend);
      if (expo.v) begin
         check("out_layer", out_layer, expo.layer);
         check("out_x", out_x, expo.x);
         check("out_y", out_y, expo.y);
      end
   endtask

   // One clock: inputs are already driven; update model at the edge and
   // compare #1 later.
   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   task automatic clr_in();
      rst = 0; in_valid = 0; in_layer = 0; in_x = 0; in_y = 0;
      cfg_we = 0; cfg_layer = 0; cfg_field = 0; cfg_data = 0; cfg_commit = 0;
   endtask

   task automatic send(input int l, input int x, input int y);
      clr_in();
      in_valid = 1; in_layer = 5'(l); in_x = 9'(x); in_y = 9'(y);
      cyc();
   endtask

   task automatic nop();
      clr_in();
      cyc();
   endtask

   task automatic cfgw(input int l, input int f, input int d);
      clr_in();
      cfg_we = 1; cfg_layer = 5'(l); cfg_field = 3'(f); cfg_data = 24'(d);
      cyc();
   endtask

   task automatic commit();
      clr_in();
      cfg_commit = 1;
      cyc();
   endtask

   task automatic probe(input int l, input int x, input int y, output bit h, output int a);
      send(l, x, y);
      nop();
      h = out_hit;
      a = int'(out_addr);
   endtask

   bit h;
   int a;
   int r;

   initial begin
      clr_in();
      rst = 1;
      cyc();
      cyc();
      check("rst_valid", out_valid, 0);
      check("rst_hit", out_hit, 0);
      check("rst_addr", out_addr, 0);
      check("rst_layer", out_layer, 0);
      check("rst_x", out_x, 0);
      check("rst_y", out_y, 0);
      check("rst_pending", commit_pending, 0);

      // Unconfigured: everything misses.
      probe(0, 0, 0, h, a);
      check("nocfg_hit", h, 0);
      for (int i = 0; i < 200; i++)
         send($urandom_range(0, NL - 1), $urandom_range(0, 479), $urandom_range(0, 271));

      // Layer 3 rectangle.
      cfgw(3, 0, 10); cfgw(3, 1, 20); cfgw(3, 2, 5); cfgw(3, 3, 4);
      cfgw(3, 4, 'h1000); cfgw(3, 5, 1);
      commit();
      check("pend_set", commit_pending, 1);
      probe(0, 0, 0, h, a);
      check("pend_clr", commit_pending, 0);
      probe(3, 12, 21, h, a);
      check("l3_a_hit", h, 1); check("l3_a_addr", a, 'h1007);
      probe(3, 15, 21, h, a);
      check("l3_b_hit", h, 0); check("l3_b_addr", a, 0);
      probe(3, 10, 23, h, a);
      check("l3_c_hit", h, 1); check("l3_c_addr", a, 'h100F);

      // Shadow-only edits stay invisible until commit + frame start.
      cfgw(3, 0, 100);
      cfgw(0, 0, 0); cfgw(0, 1, 0); cfgw(0, 2, 1); cfgw(0, 3, 1);
      cfgw(0, 4, 'h55); cfgw(0, 5, 1);
      probe(0, 0, 0, h, a);
      check("nocommit_l0", h, 0);
      probe(3, 12, 21, h, a);
      check("nocommit_l3", a, 'h1007);
      commit();
      probe(3, 12, 21, h, a);
      check("pre_fs_l3", a, 'h1007);
      probe(0, 0, 0, h, a);
      check("bypass_hit", h, 1); check("bypass_addr", a, 'h55);
      probe(3, 12, 21, h, a);
      check("new_l3_miss", h, 0);
      probe(3, 101, 21, h, a);
      check("new_l3_addr", a, 'h1006);

      // Commit in the frame-start cycle waits one frame.
      cfgw(0, 4, 'h66);
      clr_in(); in_valid = 1; cfg_commit = 1; cyc();
      check("fs_commit_pend", commit_pending, 1);
      nop();
      check("fs_commit_old", out_addr, 'h55);
      probe(0, 0, 0, h, a);
      check("fs_commit_new", a, 'h66);
      check("fs_commit_clr", commit_pending, 0);

      // Shadow write in the copy cycle: copy takes the pre-write value.
      commit();
      clr_in(); in_valid = 1; cfg_we = 1; cfg_layer = 0; cfg_field = 4; cfg_data = 'h77; cyc();
      nop();
      check("copy_prewrite", out_addr, 'h66);

      // Horizontal flip (only effective with the feature built in).
      cfgw(3, 0, 10); cfgw(3, 5, 3);
      commit();
      probe(0, 0, 0, h, a);
      probe(3, 10, 20, h, a);
`ifdef LAYER_HIT_TEST_HFLIP_EN
      check("hflip_addr", a, 'h1004);
`else
      check("hflip_addr", a, 'h1000);
`endif

      // Mid-frame reset flushes in-flight tuples and disables all layers.
      send(3, 10, 20);
      send(3, 11, 20);
      clr_in(); rst = 1; cyc();
      check("mrst_valid0", out_valid, 0);
      send(3, 12, 21);
      check("mrst_valid1", out_valid, 0);
      send(3, 12, 21);
      check("mrst_valid2", out_valid, 1);
      check("mrst_hit", out_hit, 0);

      // Randomised traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         clr_in();
         r = $urandom_range(0, 999);
         if (r < 4) rst = 1;
         if ($urandom_range(0, 99) < 85) begin
            in_valid = 1;
            if ($urandom_range(0, 99) < 2) begin
               in_layer = 0; in_x = 0; in_y = 0;
            end else begin
               in_layer = 5'(($urandom_range(0, 3) == 0) ? $urandom_range(0, NL - 1) : $urandom_range(0, 3));
               in_x = 9'($urandom_range(0, 479));
               in_y = 9'($urandom_range(0, 271));
            end
         end
         if ($urandom_range(0, 99) < 10) begin
            cfg_we    = 1;
            cfg_layer = 5'($urandom_range(0, 3));
            cfg_field = 3'($urandom_range(0, 7));
            case (cfg_field)
               3'd4:    cfg_data = 24'($urandom);
               3'd5:    cfg_data = 24'($urandom_range(0, 7) | ($urandom_range(0, 1) << 20));
               default: cfg_data = 24'($urandom_range(0, 300) | ($urandom_range(0, 1) << 12));
            endcase
         end
         if ($urandom_range(0, 99) < 3) cfg_commit = 1;
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
